// File: rtl/fp16_add_arbiter.sv
// Round-robin front end that shares one pipelined binary16 adder among NUM_REQ
// requesters and routes each result back to its originator by tag.
module fp16_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 4,
  parameter int MAX_OUT     = 2
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [15:0]            resp_result,
  output logic [15:0]            add_a,
  output logic [15:0]            add_b,
  output logic                   add_valid,
  input  logic [15:0]            add_result,
  input  logic                   add_valid_out,
  output logic                   idle,
  output logic                   tag_err
);

  localparam int                 TW       = $clog2(NUM_REQ);
  localparam int                 CW       = $clog2(MAX_OUT + 1);
  localparam int                 HD       = ADD_LATENCY;
  localparam logic [CW-1:0]      MAX_CNT  = CW'(MAX_OUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [TW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      out_cnt_q [NUM_REQ];
  logic [CW-1:0]      out_cnt_d [NUM_REQ];
  // Stage 0 travels with add_valid; stage HD lines up with add_valid_out.
  logic [TW-1:0]      tag_q [HD+1];
  logic [HD:0]        tag_v_q;
  logic [15:0]        add_a_q, add_a_d;
  logic [15:0]        add_b_q, add_b_d;
  logic               tag_err_q, tag_err_d;

  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] ret_s;
  logic [NUM_REQ-1:0] inc_s;
  logic               hs_s;
  logic               head_ok_s;
  logic               underflow_s;
  logic [TW-1:0]      win_s;
  int                 idx_s;

  assign head_ok_s = add_valid_out && tag_v_q[HD];

  // A requester whose result returns this cycle frees its slot immediately.
  always_comb begin
    elig_s = '0;
    ret_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ret_s[i]  = head_ok_s && (tag_q[HD] == TW'(i));
      elig_s[i] = req_valid[i] && ((out_cnt_q[i] < MAX_CNT) || ret_s[i]);
    end
  end

  always_comb begin
    hs_s  = 1'b0;
    win_s = '0;
    idx_s = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = int'(rr_ptr_q) + k;
      idx_s = (idx_s >= NUM_REQ) ? idx_s - NUM_REQ : idx_s;
      win_s = (!hs_s && elig_s[idx_s]) ? TW'(idx_s) : win_s;
      hs_s  = hs_s || elig_s[idx_s];
    end
  end

  assign req_ready   = hs_s ? (ONE_HOT0 << win_s) : '0;
  assign resp_valid  = head_ok_s ? (ONE_HOT0 << tag_q[HD]) : '0;
  assign resp_result = head_ok_s ? add_result : 16'h0000;

  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      add_a_d = (hs_s && (win_s == TW'(i))) ? req_a[16*i +: 16] : add_a_d;
      add_b_d = (hs_s && (win_s == TW'(i))) ? req_b[16*i +: 16] : add_b_d;
    end
  end

  // An issue and a return in the same edge cancel; a return with a zero count is dropped.
  always_comb begin
    inc_s       = '0;
    underflow_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc_s[i]     = hs_s && (win_s == TW'(i));
      out_cnt_d[i] = out_cnt_q[i];
      case ({inc_s[i], ret_s[i]})
        2'b10:   out_cnt_d[i] = out_cnt_q[i] + CW'(1);
        2'b01:   out_cnt_d[i] = (out_cnt_q[i] == '0) ? out_cnt_q[i] : out_cnt_q[i] - CW'(1);
        2'b11:   out_cnt_d[i] = (out_cnt_q[i] == '0) ? out_cnt_q[i] + CW'(1) : out_cnt_q[i];
        default: out_cnt_d[i] = out_cnt_q[i];
      endcase
      underflow_s = underflow_s || (ret_s[i] && (out_cnt_q[i] == '0));
    end
  end

  assign rr_ptr_d  = hs_s ? ((win_s == TW'(NUM_REQ - 1)) ? '0 : win_s + TW'(1)) : rr_ptr_q;
  assign tag_err_d = tag_err_q || (add_valid_out != tag_v_q[HD]) || underflow_s;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      add_a_q   <= 16'h0000;
      add_b_q   <= 16'h0000;
      tag_v_q   <= '0;
      tag_err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= '0;
      for (int s = 0; s <= HD; s++) tag_q[s] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      tag_v_q   <= {tag_v_q[HD-1:0], hs_s};
      tag_err_q <= tag_err_d;
      tag_q[0]  <= win_s;
      for (int s = 1; s <= HD; s++) tag_q[s] <= tag_q[s-1];
      for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= out_cnt_d[i];
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_valid = tag_v_q[0];
  assign tag_err   = tag_err_q;

  always_comb begin
    idle = (tag_v_q == '0);
    for (int i = 0; i < NUM_REQ; i++) idle = idle && (out_cnt_q[i] == '0);
  end

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Scoreboard bench for fp16_add_arbiter: per-requester operand sources, a
// stand-in pipelined adder, and in-order result checking.
module tb_fp16_add_arbiter;

  localparam int NR      = 4;
  localparam int ADD_LAT = 4;

  typedef struct packed { logic [15:0] a; logic [15:0] b; logic [15:0] exp; } op_t;
  typedef struct packed { logic [3:0] who; logic [15:0] res; } sb_t;

  logic              clk_in = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [16*NR-1:0]  req_a;
  logic [16*NR-1:0]  req_b;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     resp_valid;
  logic [15:0]       resp_result;
  logic [15:0]       add_a;
  logic [15:0]       add_b;
  logic              add_valid;
  logic [15:0]       add_result;
  logic              add_valid_out;
  logic              idle;
  logic              tag_err;
  logic              inject = 1'b0;

  int  total = 0;
  int  bad   = 0;
  op_t src_mem [NR][64];
  int  src_cnt [NR] = '{0, 0, 0, 0};
  int  src_head [NR] = '{0, 0, 0, 0};
  sb_t sb_q [$];

  fp16_add_arbiter #(.NUM_REQ(NR), .ADD_LATENCY(ADD_LAT), .MAX_OUT(2)) dut (
    .clk_in(clk_in), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid), .add_result(add_result),
    .add_valid_out(add_valid_out), .idle(idle), .tag_err(tag_err)
  );

  always #5 clk_in = ~clk_in;

  // Stand-in adder: exact sums for the directed pairs, an operand pattern otherwise.
  function automatic logic [15:0] adder_ref(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h4200;
      32'h3E00_3E00: return 16'h4200;
      32'h3C00_BC00: return 16'h0000;
      default:       return a ^ b;
    endcase
  endfunction

  logic [15:0]        pipe_r [ADD_LAT];
  logic [ADD_LAT-1:0] pipe_v;

  always @(posedge clk_in) begin
    if (rst) begin
      pipe_v <= '0;
      for (int k = 0; k < ADD_LAT; k++) pipe_r[k] <= 16'h0000;
    end else begin
      pipe_v    <= {pipe_v[ADD_LAT-2:0], add_valid};
      pipe_r[0] <= adder_ref(add_a, add_b);
      for (int k = 1; k < ADD_LAT; k++) pipe_r[k] <= pipe_r[k-1];
    end
  end

  assign add_valid_out = pipe_v[ADD_LAT-1] | inject;
  assign add_result    = pipe_r[ADD_LAT-1];

  // Requester drivers: present the head of each source until it is accepted.
  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(posedge clk_in);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (src_head[i] < src_cnt[i]) begin
          req_valid[i]      = 1'b1;
          req_a[16*i +: 16] = src_mem[i][src_head[i]].a;
          req_b[16*i +: 16] = src_mem[i][src_head[i]].b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard: push on handshake, pop and compare on each response strobe.
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        sb_q.delete();
        for (int i = 0; i < NR; i++) src_head[i] = src_cnt[i];
      end else begin
        if (resp_valid != 4'b0000) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL resp_unexpected: got resp_valid=%b result=%h, want no response", resp_valid, resp_result);
          end else begin
            e = sb_q.pop_front();
            if (resp_valid !== e.who || resp_result !== e.res) begin
              bad++;
              $display("FAIL resp_match: got valid=%b result=%h, want valid=%b result=%h",
                       resp_valid, resp_result, e.who, e.res);
            end
          end
        end else begin
          total++;
          if (resp_result !== 16'h0000) begin
            bad++;
            $display("FAIL resp_result_idle: got %h, want 0000", resp_result);
          end
        end
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            e.who = 4'b0001 << i;
            e.res = src_mem[i][src_head[i]].exp;
            sb_q.push_back(e);
            src_head[i]++;
          end
        end
      end
    end
  end

  task automatic push_op(input int r, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    src_mem[r][src_cnt[r]] = '{a: a, b: b, exp: exp};
    src_cnt[r]++;
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #3 rst = 1'b1;
    @(posedge clk_in);
    #3 rst = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_in);
      done = idle && (sb_q.size() == 0);
      for (int i = 0; i < NR; i++) done = done && (src_head[i] == src_cnt[i]);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_drain: got idle=%b pending=%0d, want idle=1 pending=0", name, idle, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #3 rst = 1'b0;
    @(negedge clk_in);
    total++; if (add_valid !== 1'b0) begin bad++; $display("FAIL rst_add_valid: got %b, want 0", add_valid); end
    total++; if (add_a !== 16'h0000) begin bad++; $display("FAIL rst_add_a: got %h, want 0000", add_a); end
    total++; if (add_b !== 16'h0000) begin bad++; $display("FAIL rst_add_b: got %h, want 0000", add_b); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b, want 0000", req_ready); end
    total++; if (resp_valid !== 4'b0000) begin bad++; $display("FAIL rst_resp_valid: got %b, want 0000", resp_valid); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b, want 1", idle); end
    total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL rst_tag_err: got %b, want 0", tag_err); end
  endtask

  task automatic test_single_op();
    push_op(2, 16'h3C00, 16'h4000, 16'h4200);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk_in);
      case (k)
        0: begin
          total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b, want 0100", req_ready); end
          total++; if (add_valid !== 1'b0) begin bad++; $display("FAIL single_av0: got %b, want 0", add_valid); end
        end
        1: begin
          total++; if (add_valid !== 1'b1) begin bad++; $display("FAIL single_av1: got %b, want 1", add_valid); end
          total++; if (add_a !== 16'h3C00 || add_b !== 16'h4000) begin
            bad++; $display("FAIL single_operands: got %h/%h, want 3c00/4000", add_a, add_b); end
        end
        2: begin
          total++; if (add_valid !== 1'b0) begin bad++; $display("FAIL single_av2: got %b, want 0", add_valid); end
        end
        3: begin
          total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_busy: got idle=%b, want 0", idle); end
        end
        5: begin
          total++; if (resp_valid !== 4'b0100 || resp_result !== 16'h4200) begin
            bad++; $display("FAIL single_resp: got %b/%h, want 0100/4200", resp_valid, resp_result); end
        end
        6: begin
          total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle: got %b, want 1", idle); end
        end
        default: begin
          total++; if (resp_valid !== 4'b0000) begin bad++; $display("FAIL single_early: got %b, want 0000", resp_valid); end
        end
      endcase
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 4; j++)
        push_op(i, 16'h1000 + 16'(i * 256 + j), 16'h0011, (16'h1000 + 16'(i * 256 + j)) ^ 16'h0011);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_in);
      want = 4'b0001 << (k % 4);
      total++; if (req_ready !== want) begin bad++; $display("FAIL fair_grant_%0d: got %b, want %b", k, req_ready, want); end
      if (k >= 1) begin
        total++; if (add_valid !== 1'b1) begin bad++; $display("FAIL fair_av_%0d: got %b, want 1", k, add_valid); end
      end
    end
    wait_drain("fair");
  endtask

  task automatic test_out_limit();
    logic [11:0] pat = 12'b110001100011;
    logic [3:0]  want;
    for (int j = 0; j < 6; j++) push_op(1, 16'h2000 + 16'(j), 16'h0100, (16'h2000 + 16'(j)) ^ 16'h0100);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_in);
      want = pat[k] ? 4'b0010 : 4'b0000;
      total++; if (req_ready !== want) begin bad++; $display("FAIL limit_ready_%0d: got %b, want %b", k, req_ready, want); end
    end
    wait_drain("limit");
  endtask

  task automatic test_simultaneous();
    push_op(0, 16'h3E00, 16'h3E00, 16'h4200);
    push_op(0, 16'h3C00, 16'hBC00, 16'h0000);
    push_op(0, 16'h3E00, 16'h3E00, 16'h4200);
    push_op(0, 16'h3C00, 16'hBC00, 16'h0000);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_in);
      case (k)
        5: begin
          total++; if (resp_valid !== 4'b0001 || req_ready !== 4'b0001 || resp_result !== 16'h4200) begin
            bad++; $display("FAIL simul_c5: got resp=%b ready=%b res=%h, want 0001/0001/4200", resp_valid, req_ready, resp_result); end
        end
        6: begin
          total++; if (resp_valid !== 4'b0001 || req_ready !== 4'b0001 || resp_result !== 16'h0000) begin
            bad++; $display("FAIL simul_c6: got resp=%b ready=%b res=%h, want 0001/0001/0000", resp_valid, req_ready, resp_result); end
        end
        7: begin
          total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL simul_hold: got %b, want 0000", req_ready); end
        end
        10: begin
          total++; if (resp_result !== 16'h4200) begin bad++; $display("FAIL simul_r3: got %h, want 4200", resp_result); end
        end
        11: begin
          total++; if (resp_result !== 16'h0000 || resp_valid !== 4'b0001) begin
            bad++; $display("FAIL simul_r4: got %b/%h, want 0001/0000", resp_valid, resp_result); end
        end
        default: ;
      endcase
    end
    wait_drain("simul");
  endtask

  task automatic test_reset_mid();
    push_op(0, 16'h0101, 16'h0202, 16'h0303);
    push_op(1, 16'h0404, 16'h0808, 16'h0C0C);
    push_op(2, 16'h1111, 16'h2222, 16'h3333);
    repeat (3) @(negedge clk_in);
    @(posedge clk_in);
    #3 rst = 1'b1;
    @(posedge clk_in);
    #3 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      total++; if (resp_valid !== 4'b0000) begin bad++; $display("FAIL rmid_resp_%0d: got %b, want 0000", k, resp_valid); end
      if (k == 0) begin
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rmid_idle: got %b, want 1", idle); end
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL rmid_tag_err: got %b, want 0", tag_err); end
      end
    end
    push_op(3, 16'h3C00, 16'h4000, 16'h4200);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk_in);
      if (k == 5) begin
        total++; if (resp_valid !== 4'b1000 || resp_result !== 16'h4200) begin
          bad++; $display("FAIL rmid_new: got %b/%h, want 1000/4200", resp_valid, resp_result); end
      end
    end
    wait_drain("rmid");
  endtask

  task automatic test_error_inject();
    @(posedge clk_in);
    #1 inject = 1'b1;
    @(negedge clk_in);
    total++; if (resp_valid !== 4'b0000 || resp_result !== 16'h0000) begin
      bad++; $display("FAIL inj_resp: got %b/%h, want 0000/0000", resp_valid, resp_result); end
    @(posedge clk_in);
    #1 inject = 1'b0;
    @(negedge clk_in);
    total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL inj_tag_err: got %b, want 1", tag_err); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL inj_idle: got %b, want 1", idle); end
    push_op(0, 16'h0A0A, 16'h0505, 16'h0F0F);
    push_op(0, 16'h0C0C, 16'h0303, 16'h0F0F);
    push_op(0, 16'h0001, 16'h0002, 16'h0003);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      total++; if (req_ready !== ((k < 2) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL inj_cnt_%0d: got %b, want %b", k, req_ready, (k < 2) ? 4'b0001 : 4'b0000); end
    end
    wait_drain("inj");
    total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL inj_sticky: got %b, want 1", tag_err); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_out_limit();
    test_simultaneous();
    test_reset_mid();
    test_error_inject();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
